dice_roll_ctrl: RTL

- Button-side responder for the two-player dice game: consumes the raw start1/start2 hold-to-roll / release-to-stop buttons and produces the rolling dice values.
- Also produces per-player done flags and a judged round result.
- Its outputs feed the existing matrix, seven-segment and RGB display logic.
- Contains per-player debounce, per-player roll FSM with free-running LFSR, and a round/judge FSM.

---
 rtl/dice_roll_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dice_roll_ctrl.sv
// Two-player dice controller: debounces the hold-to-roll buttons, runs one roll FSM
// and one free-running LFSR per player, and judges each round once both have stopped.
//
// player state | meaning
// P_IDLE       | blank die, waiting for a press
// P_ROLL       | button held, die follows the LFSR every cycle
// P_HOLD       | button released, die frozen until the next round
//
// round state  | meaning
// R_WAIT       | at least one player has not stopped yet
// R_JUDGE      | single cycle, compares the frozen faces
// R_SHOW       | result valid; any press starts a new round
module dice_roll_ctrl #(
    parameter int unsigned DEB_CYCLES = 20,
    parameter logic [7:0]  SEED1      = 8'hA5,
    parameter logic [7:0]  SEED2      = 8'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start1,
    input  logic       start2,
    output logic [3:0] dice1,
    output logic [3:0] dice2,
    output logic       rolling1,
    output logic       rolling2,
    output logic       done1,
    output logic       done2,
    output logic [1:0] result,
    output logic       result_valid
);

    localparam int unsigned    CW        = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(DEB_CYCLES - 1);
    localparam logic [7:0]     SEED1_EFF = (SEED1 == 8'h00) ? 8'h01 : SEED1;
    localparam logic [7:0]     SEED2_EFF = (SEED2 == 8'h00) ? 8'h01 : SEED2;

    typedef enum logic [1:0] {P_IDLE, P_ROLL, P_HOLD} pstate_t;
    typedef enum logic [1:0] {R_WAIT, R_JUDGE, R_SHOW} rstate_t;

    logic [1:0]    raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d, deb_prev_q;
    logic [1:0]    rise, fall;
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];
    logic [7:0]    lfsr_q [2];
    logic [7:0]    lfsr_d [2];
    logic [3:0]    dice_q [2];
    logic [3:0]    dice_d [2];
    pstate_t       pst_q  [2];
    pstate_t       pst_d  [2];
    rstate_t       rnd_q, rnd_d;
    logic [1:0]    res_q, res_d;
    logic          restart;

    function automatic logic [3:0] face(input logic [7:0] v);
        logic [7:0] m;
        m = v % 8'd6;
        return m[3:0] + 4'd1;
    endfunction

    assign raw  = {start2, start1};
    assign rise = deb_q & ~deb_prev_q;
    assign fall = ~deb_q & deb_prev_q;

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            lfsr_d[i] = {lfsr_q[i][6:0], lfsr_q[i][7] ^ lfsr_q[i][5] ^ lfsr_q[i][4] ^ lfsr_q[i][3]};
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = ~deb_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // A press seen in SHOW overrides the normal player transitions for both players.
    assign restart = (rnd_q == R_SHOW) && (rise != 2'b00);

    always_comb begin
        pst_d  = pst_q;
        dice_d = dice_q;
        for (int i = 0; i < 2; i++) begin
            if (restart) begin
                pst_d[i]  = rise[i] ? P_ROLL : P_IDLE;
                dice_d[i] = '0;
            end else begin
                unique case (pst_q[i])
                    P_IDLE: begin
                        if (rise[i] && (rnd_q != R_JUDGE)) pst_d[i] = P_ROLL;
                    end
                    P_ROLL: begin
                        dice_d[i] = face(lfsr_q[i]);
                        if (fall[i] && (rnd_q != R_JUDGE)) pst_d[i] = P_HOLD;
                    end
                    P_HOLD: pst_d[i] = P_HOLD;
                    default: begin
                        pst_d[i]  = P_IDLE;
                        dice_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rnd_d = rnd_q;
        res_d = res_q;
        unique case (rnd_q)
            R_WAIT: begin
                if ((pst_q[0] == P_HOLD) && (pst_q[1] == P_HOLD)) rnd_d = R_JUDGE;
            end
            R_JUDGE: begin
                rnd_d = R_SHOW;
                if (dice_q[0] > dice_q[1])      res_d = 2'b01;
                else if (dice_q[0] < dice_q[1]) res_d = 2'b10;
                else                            res_d = 2'b11;
            end
            R_SHOW: begin
                if (restart) begin
                    rnd_d = R_WAIT;
                    res_d = 2'b00;
                end
            end
            default: begin
                rnd_d = R_WAIT;
                res_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            lfsr_q[0]  <= SEED1_EFF;
            lfsr_q[1]  <= SEED2_EFF;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]  <= '0;
                dice_q[i] <= '0;
                pst_q[i]  <= P_IDLE;
            end
            rnd_q      <= R_WAIT;
            res_q      <= 2'b00;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                lfsr_q[i] <= lfsr_d[i];
                cnt_q[i]  <= cnt_d[i];
                dice_q[i] <= dice_d[i];
                pst_q[i]  <= pst_d[i];
            end
            rnd_q      <= rnd_d;
            res_q      <= res_d;
        end
    end

    assign dice1        = dice_q[0];
    assign dice2        = dice_q[1];
    assign rolling1     = (pst_q[0] == P_ROLL);
    assign rolling2     = (pst_q[1] == P_ROLL);
    assign done1        = (pst_q[0] == P_HOLD);
    assign done2        = (pst_q[1] == P_HOLD);
    assign result       = res_q;
    assign result_valid = (rnd_q == R_SHOW);

endmodule
